// File: rtl/xor_share_pkg.sv
// Shared types and constants for the two-requester XOR arbiter.
//   state_e : arbiter FSM states
//   ID_W    : width of the requester tag
//   NUM_REQ : number of requesters sharing the datapath
package xor_share_pkg;

    localparam int unsigned ID_W    = 1;
    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage : xor_share_pkg

// File: rtl/XOR_gate.sv
// Single-bit XOR cell.
//   A, B : operand bits
//   C    : A ^ B
module XOR_gate (
    input  logic A,
    input  logic B,
    output logic C
);

    assign C = A ^ B;

endmodule : XOR_gate

// File: rtl/xor_word.sv
// Word-wide combinational XOR built from one XOR_gate per bit.
//   a_i, b_i : WIDTH-bit operands
//   c_o      : WIDTH-bit result a_i ^ b_i
module xor_word #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] c_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        XOR_gate u_xor (
            .A (a_i[i]),
            .B (b_i[i]),
            .C (c_o[i])
        );
    end

endmodule : xor_word

// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter sharing one XOR datapath between two requesters.
//   clk, rst              : clock, synchronous active-high reset
//   reqN_valid/A/B/ready  : request channel N (ready is a combinational grant)
//   rsp_valid/ready/id/C  : registered result channel tagged with owner
//   done_cnt0/1           : wrapping completion counters per requester
module xor_share_arbiter
    import xor_share_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ID_W-1:0]  rsp_id,
    output logic [WIDTH-1:0] rsp_C,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1
);

    state_e            state_q;
    logic [ID_W-1:0]   prio_q;
    logic [ID_W-1:0]   id_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [WIDTH-1:0]  rsp_c_q;
    logic [CNT_W-1:0]  cnt0_q;
    logic [CNT_W-1:0]  cnt1_q;

    logic              gnt_valid;
    logic [ID_W-1:0]   gnt_id;
    logic [WIDTH-1:0]  xor_c;

    // Grant only in IDLE; on contention the priority holder wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = prio_q;
            end else if (req0_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = ID_W'(0);
            end else if (req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = ID_W'(1);
            end
        end
    end

    assign req0_ready = gnt_valid && (gnt_id == ID_W'(0));
    assign req1_ready = gnt_valid && (gnt_id == ID_W'(1));

    // The single shared datapath, fed from the operand registers.
    xor_word #(
        .WIDTH (WIDTH)
    ) u_xor_word (
        .a_i (a_q),
        .b_i (b_q),
        .c_o (xor_c)
    );

    // Arbiter FSM, operand/result registers and completion counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_c_q     <= '0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        a_q     <= (gnt_id == ID_W'(0)) ? req0_A : req1_A;
                        b_q     <= (gnt_id == ID_W'(0)) ? req0_B : req1_B;
                        id_q    <= gnt_id;
                        prio_q  <= ~gnt_id;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    rsp_c_q     <= xor_c;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (rsp_id_q == ID_W'(0)) begin
                            cnt0_q <= cnt0_q + CNT_W'(1);
                        end else begin
                            cnt1_q <= cnt1_q + CNT_W'(1);
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_C     = rsp_c_q;
    assign done_cnt0 = cnt0_q;
    assign done_cnt1 = cnt1_q;

endmodule : xor_share_arbiter
